// File: rtl/wr_arbiter.sv
// -----------------------------------------------------------------------------
// wr_arbiter
//
// Shares one W-bit holding register among N requesters. Each cycle in IDLE the
// arbiter picks one eligible requester, pulses its grant, and loads its data
// into the register. After every write it forces GAP idle cycles before the
// next grant, so consumers of q see a stable value for at least GAP+1 cycles.
//
// Configuration macro:
//   WR_ARBITER_RR_EN  defined   -> round-robin arbitration (search starts one
//                                  past the last winner)
//                     undefined -> fixed priority (lowest index wins)
//
// Parameters:
//   N    number of requesters, 2..8
//   W    data width per requester and width of q
//   GAP  idle cycles forced after each write, 0..15
//
// Ports:
//   clk     in   rising-edge clock
//   resetn  in   synchronous active-low reset
//   req     in   [N]    per-requester write request (level)
//   data    in   [N*W]  requester i data on bits [i*W +: W]
//   gnt     out  [N]    one-hot grant, one-cycle pulse
//   en_out  out         write strobe, high in the cycle q takes new data
//   q       out  [W]    shared register contents
//   q_src   out  [clog2(N)] index of the last writer
//   busy    out         high for the GAP cycles that follow each write
//
// All outputs come straight from flops; nothing from req/data reaches an
// output combinationally.
// -----------------------------------------------------------------------------
module wr_arbiter #(
    parameter int N   = 4,
    parameter int W   = 4,
    parameter int GAP = 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [N-1:0]           req,
    input  logic [N*W-1:0]         data,
    output logic [N-1:0]           gnt,
    output logic                   en_out,
    output logic [W-1:0]           q,
    output logic [$clog2(N)-1:0]   q_src,
    output logic                   busy
);

    localparam int SW = $clog2(N);

    typedef enum logic {
        S_IDLE,
        S_GAP
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic           en_q, en_d;
    logic [W-1:0]   q_q, q_d;
    logic [SW-1:0]  src_q, src_d;
    logic           busy_q, busy_d;

`ifdef WR_ARBITER_RR_EN
    logic [SW-1:0]  ptr_q, ptr_d;
`endif

    // A requester still holding req during its own grant cycle is masked so
    // it cannot be granted twice for one request.
    logic [N-1:0]   elig;
    logic           win_valid;
    logic [SW-1:0]  win_idx;
    logic [W-1:0]   win_data;

    assign elig = req & ~gnt_q;

    // Winner selection.
    // NOTE: every signal written in an always_comb block gets a default on
    // entry; a path that leaves one unassigned would infer a latch.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
`ifdef WR_ARBITER_RR_EN
        // Walk the ring starting one past the last winner.
        for (int k = 0; k < N; k++) begin
            if (!win_valid && elig[(int'(ptr_q) + 1 + k) % N]) begin
                win_valid = 1'b1;
                win_idx   = SW'((int'(ptr_q) + 1 + k) % N);
            end
        end
`else
        for (int i = 0; i < N; i++) begin
            if (!win_valid && elig[i]) begin
                win_valid = 1'b1;
                win_idx   = SW'(i);
            end
        end
`endif
    end

    assign win_data = data[int'(win_idx)*W +: W];

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        en_d    = 1'b0;
        q_d     = q_q;
        src_d   = src_q;
        busy_d  = 1'b0;
`ifdef WR_ARBITER_RR_EN
        ptr_d   = ptr_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    gnt_d = N'(1) << win_idx;
                    en_d  = 1'b1;
                    q_d   = win_data;
                    src_d = win_idx;
`ifdef WR_ARBITER_RR_EN
                    ptr_d = win_idx;
`endif
                    if (GAP > 0) begin
                        state_d = S_GAP;
                        cnt_d   = 4'(GAP);
                    end
                end
            end

            S_GAP: begin
                // busy trails the GAP state by one cycle: the write cycle
                // itself is not busy, and the last busy cycle coincides with
                // IDLE so the next grant lands exactly GAP+1 cycles after
                // the previous one.
                busy_d = 1'b1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            gnt_q   <= '0;
            en_q    <= 1'b0;
            q_q     <= '0;
            src_q   <= '0;
            busy_q  <= 1'b0;
`ifdef WR_ARBITER_RR_EN
            // Starting at N-1 makes the first search begin at index 0.
            ptr_q   <= SW'(N - 1);
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            en_q    <= en_d;
            q_q     <= q_d;
            src_q   <= src_d;
            busy_q  <= busy_d;
`ifdef WR_ARBITER_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign gnt    = gnt_q;
    assign en_out = en_q;
    assign q      = q_q;
    assign q_src  = src_q;
    assign busy   = busy_q;

endmodule
